// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between display scan-out
// (strict priority, fixed 3-clk read latency) and a FIFO-buffered pixel writer
// that drains on cycles the display leaves free.
// Optional feature macro: VRAM_STARVE_GUARD_EN. It adds a starve counter that
// steals one display cycle for the writer after STARVE_LIM consecutive
// full-FIFO clocks and reports the lost read on disp_miss.
module vram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_req,
  input  logic [AW-1:0]                 disp_addr,
  output logic [DW-1:0]                 disp_data,
  output logic                          disp_data_valid,
  output logic                          disp_miss,
  input  logic                          wr_valid,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic steal;
  logic grant_disp;
  logic grant_wr;

  // read issued at N+1, data back from RAM at N+2
  logic rd_s2;

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign wr_ready   = !fifo_full;
  assign fifo_level = level;
  assign push       = wr_valid && !fifo_full;
  assign pop        = grant_wr;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_LIM + 1);

  logic [SCW-1:0] starve_cnt;
  logic           miss_s1;
  logic           miss_s2;

  // Counter at its limit means the FIFO was full last clk, so at most one
  // entry has left since and the FIFO cannot be empty; the empty gate is a
  // belt-and-braces guard.
  assign steal = disp_req && (starve_cnt == SCW'(STARVE_LIM)) && !fifo_empty;

  // count consecutive full-FIFO clocks, saturating; a steal restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!fifo_full || steal) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SCW'(STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // carry a stolen display request down the pipe so the miss lines up with N+3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_s1   <= 1'b0;
      miss_s2   <= 1'b0;
      disp_miss <= 1'b0;
    end else begin
      miss_s1   <= steal;
      miss_s2   <= miss_s1;
      disp_miss <= miss_s2;
    end
  end
`else
  logic unused_starve_lim;

  assign unused_starve_lim = (STARVE_LIM > 0);
  assign steal             = 1'b0;
  assign disp_miss         = 1'b0;
`endif

  // per-clk arbitration: display first unless the guard steals the slot
  always_comb begin
    grant_disp = disp_req && !steal;
    grant_wr   = !grant_disp && !fifo_empty;
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (!push && pop) begin
        level <= level - 1'b1;
      end
    end
  end

  // register the granted access onto the RAM port; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= grant_disp || grant_wr;
      mem_we <= grant_wr;
      if (grant_disp) begin
        mem_addr <= disp_addr;
      end else if (grant_wr) begin
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end
    end
  end

  // return read data to the display three clocks after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s2           <= 1'b0;
      disp_data_valid <= 1'b0;
      disp_data       <= '0;
    end else begin
      rd_s2           <= mem_en && !mem_we;
      disp_data_valid <= rd_s2;
      if (rd_s2) disp_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model (write queue, shadow memory, result queue).
module tb_vram_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic                       clk;
  logic                       rst_n;
  logic                       disp_req;
  logic [AW-1:0]              disp_addr;
  logic [DW-1:0]              disp_data;
  logic                       disp_data_valid;
  logic                       disp_miss;
  logic                       wr_valid;
  logic [AW-1:0]              wr_addr;
  logic [DW-1:0]              wr_data;
  logic                       wr_ready;
  logic [$clog2(DEPTH):0]     fifo_level;
  logic                       mem_en;
  logic                       mem_we;
  logic [AW-1:0]              mem_addr;
  logic [DW-1:0]              mem_wdata;
  logic [DW-1:0]              mem_rdata;

  vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_data_valid(disp_data_valid), .disp_miss(disp_miss),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_level(fifo_level),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h0123) return 12'hABC;
    return DW'(a * 37 + 5);
  endfunction

  // RAM macro stand-in: registered read, one-cycle latency
  logic [DW-1:0] ram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_val(mem_addr);
    end
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic miss; logic [DW-1:0] d; } res_t;

  wr_t           wq[$];
  res_t          pq[$];
  logic [DW-1:0] shadow [int];
  int            cyc;
  int            m_level;
  int            m_starve;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            checks;
  int            failures;

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    pq.delete();
    m_level  = 0;
    m_starve = 0;
    e_en     = 1'b0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_wdata  = '0;
  endtask

  // one clock: predict from current inputs, advance, compare
  task automatic tick();
    bit   steal, g_disp, g_wr, acc, full_before, ev, em;
    wr_t  w;
    res_t r;
    logic [DW-1:0] ed;
    steal = 0;
    full_before = (m_level == DEPTH);
`ifdef VRAM_STARVE_GUARD_EN
    steal = disp_req && (m_starve == LIM) && (m_level > 0);
`endif
    g_disp = disp_req && !steal;
    g_wr   = !g_disp && (m_level > 0);
    acc    = wr_valid && (m_level < DEPTH);
    if (g_disp) begin
      e_en = 1'b1; e_we = 1'b0; e_addr = disp_addr;
      pq.push_back('{cyc + 3, 1'b0, sh_rd(disp_addr)});
    end else if (g_wr) begin
      w = wq.pop_front();
      e_en = 1'b1; e_we = 1'b1; e_addr = w.a; e_wdata = w.d;
      shadow[int'(w.a)] = w.d;
      if (steal) pq.push_back('{cyc + 3, 1'b1, '0});
    end else begin
      e_en = 1'b0;
    end
    if (acc) wq.push_back('{wr_addr, wr_data});
    m_level = m_level + int'(acc) - int'(g_wr);
    if (!full_before || steal) m_starve = 0;
    else if (m_starve < LIM) m_starve++;

    @(posedge clk);
    #1;
    cyc++;

    ev = 0; em = 0; ed = '0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      r  = pq.pop_front();
      ev = !r.miss; em = r.miss; ed = r.d;
    end
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_en && e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("fifo_level", 32'(fifo_level), 32'(m_level));
    chk("wr_ready", 32'(wr_ready), 32'(m_level < DEPTH));
    chk("disp_data_valid", 32'(disp_data_valid), 32'(ev));
    chk("disp_miss", 32'(disp_miss), 32'(em));
    if (ev) chk("disp_data", 32'(disp_data), 32'(ed));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_disp_data"}, 32'(disp_data), 32'd0);
    chk({tag, "_disp_valid"}, 32'(disp_data_valid), 32'd0);
    chk({tag, "_disp_miss"}, 32'(disp_miss), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // single display read of a known location
    disp_req = 1'b1; disp_addr = 16'h0123;
    tick();
    disp_req = 1'b0;
    repeat (4) tick();

    // blanking drain of four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(10 + i); wr_data = DW'(1 + i);
      tick();
    end
    wr_valid = 1'b0;
    repeat (4) tick();

    // display holds the RAM: FIFO fills, fifth write refused, then drains in order
    disp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      disp_addr = AW'(100 + i);
      wr_valid = 1'b1; wr_addr = AW'(20 + i); wr_data = DW'(12'h100 + i);
      tick();
    end
    wr_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) tick();
    disp_req = 1'b0;
    repeat (6) tick();

    // simultaneous push/pop at level 2
    disp_req = 1'b1; disp_addr = 16'h0011;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(30 + i); wr_data = DW'(12'h200 + i);
      tick();
    end
    disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(32 + i); wr_data = DW'(12'h210 + i);
      tick();
      chk("pushpop_level", 32'(fifo_level), 32'd2);
    end
    wr_valid = 1'b0;
    repeat (4) tick();

    // continuous display with a full FIFO: starvation (guard steals when built)
    disp_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      disp_addr = AW'($urandom_range(0, 15));
      wr_valid = 1'b1; wr_addr = AW'($urandom_range(0, 15)); wr_data = DW'($urandom);
      tick();
    end
    wr_valid = 1'b0; disp_req = 1'b0;
    repeat (6) tick();

    // randomized traffic at several display loads
    for (int blk = 0; blk < 4; blk++) begin
      int p;
      p = (blk == 0) ? 30 : (blk == 1) ? 70 : (blk == 2) ? 95 : 50;
      for (int i = 0; i < 100; i++) begin
        disp_req  = ($urandom_range(0, 99) < p);
        disp_addr = AW'($urandom_range(0, 15));
        wr_valid  = ($urandom_range(0, 99) < 60);
        wr_addr   = AW'($urandom_range(0, 15));
        wr_data   = DW'($urandom);
        tick();
      end
    end

    // reset in the middle of a read burst with writes queued
    disp_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp_addr = AW'(40 + i);
      wr_valid = 1'b1; wr_addr = AW'(50 + i); wr_data = DW'(12'h300 + i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    disp_req = 1'b0; wr_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    repeat (5) tick();

    // traffic after reset
    for (int i = 0; i < 60; i++) begin
      disp_req  = ($urandom_range(0, 99) < 50);
      disp_addr = AW'($urandom_range(0, 15));
      wr_valid  = ($urandom_range(0, 99) < 50);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = DW'($urandom);
      tick();
    end
    disp_req = 1'b0; wr_valid = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
